// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Also used by the companion transmitter.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 868;
   localparam int HALF_BIT = CLKS_PER_BIT_DEFAULT / 2;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to the idle (high) level so no false start follows reset.
module rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rxS
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         rxS  <= 1'b1;
      end else begin
         meta <= rx;
         rxS  <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a shift-style
// history buffer of the last BUF_DEPTH good bytes.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int BUF_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RX,
   input  logic       bufClear,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       frameError,
   output logic [7:0] RXBUF [BUF_DEPTH],
   output logic [7:0] outLight
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);

   logic          rxS;
   logic          rx_prev;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   rx_sync u_sync (
      .clk  (clk),
      .reset(reset),
      .rx   (RX),
      .rxS  (rxS)
   );

   assign outLight = RXBUF[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         rxData     <= '0;
         rxValid    <= 1'b0;
         frameError <= 1'b0;
         rx_prev    <= 1'b1;
         for (int i = 0; i < BUF_DEPTH; i++) RXBUF[i] <= '0;
      end else begin
         rx_prev <= rxS;
         rxValid <= 1'b0;
         if (bufClear) begin
            for (int i = 0; i < BUF_DEPTH; i++) RXBUF[i] <= '0;
         end
         unique case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (rx_prev && !rxS) state <= START;
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= rxS ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rxS, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (rxS) begin
                     rxData     <= shreg;
                     rxValid    <= 1'b1;
                     frameError <= 1'b0;
                     // a simultaneous clear drops the byte from history
                     if (!bufClear) begin
                        for (int i = BUF_DEPTH - 1; i > 0; i--)
                           RXBUF[i] <= RXBUF[i-1];
                        RXBUF[0] <= shreg;
                     end
                  end else begin
                     frameError <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
